// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared CPU constants (opcodes, unit encodings, decode
// bundle bit positions), the skid-buffer state type and the stored entry.
package decode_stage_pkg;
    localparam int CPU_XLEN = 32;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_LSU = 2'd1;
    localparam logic [1:0] UNIT_SYS = 2'd2;
    localparam logic [2:0] SUB_ALU_REG = 3'd0;
    localparam logic [2:0] SUB_BRANCH  = 3'd1;
    localparam logic [2:0] SUB_ALU_IMM = 3'd2;
    localparam logic [2:0] SUB_LUI     = 3'd3;
    localparam logic [2:0] SUB_AUIPC   = 3'd4;
    localparam logic [2:0] SUB_JAL     = 3'd5;
    localparam logic [2:0] SUB_JALR    = 3'd6;
    localparam logic [2:0] SUB_LOAD    = 3'd0;
    localparam logic [2:0] SUB_STORE   = 3'd1;
    localparam logic [2:0] SUB_CSR     = 3'd0;
    localparam logic [2:0] SUB_ENV     = 3'd1;
    localparam logic [2:0] SUB_FENCE   = 3'd2;
    localparam int DEC_CALC_J  = 0;
    localparam int DEC_ILLEGAL = 1;
    localparam int DEC_EBREAK  = 2;
    localparam int DEC_ECALL   = 3;
    localparam int DEC_FENCE   = 4;
    localparam int DEC_IMM     = 5;
    localparam int DEC_W       = 15;
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [DEC_W-1:0]    decode;
        logic [CPU_XLEN-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                rd_we;
        logic [11:0]         csr;
    } dec_entry_t;
endpackage

// File: rtl/decode_stage_class_dec.sv
// class_dec: instruction-class decoder producing the 15-bit decode bundle
// {unit, sub_unit, sel, imm, fence, ecall, ebreak, illegal, calc_j}.
// Ports: in_instr (raw instruction) -> out_decode (bundle).
module class_dec
    import decode_stage_pkg::*;
(
    input  logic [31:0]      in_instr,
    output logic [DEC_W-1:0] out_decode
);
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [1:0] w_unit;
    logic [2:0] w_sub;
    logic [3:0] w_sel;
    logic       w_imm, w_fence, w_ecall, w_ebreak, w_ill, w_calc_j;
    assign w_f3 = in_instr[14:12];
    assign w_f7 = in_instr[31:25];
    always_comb begin
        w_unit   = UNIT_ALU;
        w_sub    = SUB_ALU_REG;
        w_sel    = '0;
        w_imm    = 1'b0;
        w_fence  = 1'b0;
        w_ecall  = 1'b0;
        w_ebreak = 1'b0;
        w_ill    = 1'b0;
        w_calc_j = 1'b0;
        case (in_instr[6:0])
            OP_LUI:    begin w_sub = SUB_LUI; w_imm = 1'b1; end
            OP_AUIPC:  begin w_sub = SUB_AUIPC; w_imm = 1'b1; end
            OP_JAL:    begin w_sub = SUB_JAL; w_calc_j = 1'b1; end
            OP_JALR:   begin w_sub = SUB_JALR; w_calc_j = 1'b1; w_ill = w_f3 != 3'd0; end
            OP_BRANCH: begin w_sub = SUB_BRANCH; w_calc_j = 1'b1; w_sel = {1'b0, w_f3}; w_ill = w_f3[2:1] == 2'b01; end
            OP_LOAD:   begin w_unit = UNIT_LSU; w_sub = SUB_LOAD; w_imm = 1'b1; w_sel = {1'b0, w_f3}; w_ill = w_f3 == 3'd3 || w_f3[2:1] == 2'b11; end
            OP_STORE:  begin w_unit = UNIT_LSU; w_sub = SUB_STORE; w_imm = 1'b1; w_sel = {1'b0, w_f3}; w_ill = w_f3[2] || w_f3[1:0] == 2'b11; end
            OP_OP_IMM: begin w_sub = SUB_ALU_IMM; w_imm = 1'b1; w_sel = {w_f3 == 3'd5 && in_instr[30], w_f3}; end
            OP_OP: begin
                w_sel = {in_instr[30], w_f3};
                w_ill = w_f7 != 7'h00 && !(w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
            end
            OP_MISC_MEM: begin w_unit = UNIT_SYS; w_sub = SUB_FENCE; w_fence = 1'b1; end
            OP_SYSTEM: begin
                w_unit   = UNIT_SYS;
                w_sub    = w_f3 == 3'd0 ? SUB_ENV : SUB_CSR;
                w_sel    = w_f3 == 3'd0 ? 4'd0 : {1'b0, w_f3};
                w_imm    = w_f3[2];
                w_ecall  = w_f3 == 3'd0 && in_instr[31:7] == 25'h0;
                w_ebreak = w_f3 == 3'd0 && in_instr[31:7] == 25'h2000;
                w_ill    = w_f3 == 3'd4 || (w_f3 == 3'd0 && !(w_ecall || w_ebreak));
            end
            default: w_ill = 1'b1;
        endcase
    end
    assign out_decode = {w_unit, w_sub, w_sel, w_imm, w_fence, w_ecall, w_ebreak, w_ill, w_calc_j};
endmodule

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate expansion by opcode.
// Ports: in_instr (raw instruction) -> out_imm (XLEN-wide immediate).
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = CPU_XLEN
) (
    input  logic [31:0]     in_instr,
    output logic [XLEN-1:0] out_imm
);
    logic w_s;
    assign w_s = in_instr[31];
    always_comb begin
        out_imm = '0;
        case (in_instr[6:0])
            OP_LOAD, OP_OP_IMM, OP_JALR: out_imm = {{(XLEN-12){w_s}}, in_instr[31:20]};
            OP_STORE:         out_imm = {{(XLEN-12){w_s}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH:        out_imm = {{(XLEN-12){w_s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: out_imm = {{(XLEN-31){w_s}}, in_instr[30:12], 12'b0};
            OP_JAL:           out_imm = {{(XLEN-20){w_s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            OP_SYSTEM:        out_imm = in_instr[14] ? XLEN'(in_instr[19:15]) : '0;
            default:          out_imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch->execute decode stage with a 2-entry skid buffer so
// out_ready never reaches in_ready combinationally.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_pc/in_instr from
// fetch; flush from execute; out_valid/out_ready and the head entry fields
// (out_pc, out_decode, out_imm, out_rs1/rs2/rd, out_rd_we, out_csr) to
// execute; perf_stall_in/perf_stall_out stall counters.
// Optional: DECODE_STAGE_PERF_EN enables the stall counters (else tied to 0).
// XLEN must equal CPU_XLEN, which sizes the stored entry.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = CPU_XLEN,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [DEC_W-1:0]  out_decode,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [11:0]       out_csr,
    output logic [PERF_W-1:0] perf_stall_in,
    output logic [PERF_W-1:0] perf_stall_out
);
    state_t           r_state, w_next;
    dec_entry_t       r_head, r_tail, w_new;
    logic [XLEN-1:0]  w_imm;
    logic [DEC_W-1:0] w_cls, w_dec;
    logic             w_acc, w_emit, w_load_head, w_load_tail, w_shift, w_rd_we;
    imm_gen #(.XLEN(XLEN)) u_imm (.in_instr(in_instr), .out_imm(w_imm));
    class_dec u_dec (.in_instr(in_instr), .out_decode(w_cls));
    // Non-32-bit encodings are illegal on top of whatever the decoder says.
    assign w_dec = {w_cls[DEC_W-1:DEC_ILLEGAL+1], w_cls[DEC_ILLEGAL] | (in_instr[1:0] != 2'b11), w_cls[DEC_ILLEGAL-1:0]};
    assign w_rd_we = !(in_instr[6:0] == OP_BRANCH || in_instr[6:0] == OP_STORE || w_dec[DEC_FENCE] ||
                       w_dec[DEC_ECALL] || w_dec[DEC_EBREAK] || w_dec[DEC_ILLEGAL] || in_instr[11:7] == 5'd0);
    assign w_new = '{pc: in_pc, decode: w_dec, imm: w_imm, rs1: in_instr[19:15], rs2: in_instr[24:20],
                     rd: in_instr[11:7], rd_we: w_rd_we, csr: in_instr[31:20]};
    assign in_ready  = r_state != S_TWO && !rst;
    assign out_valid = r_state != S_EMPTY;
    assign w_acc     = in_valid && in_ready;
    assign w_emit    = out_valid && out_ready;
    always_comb begin
        w_next      = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_next      = w_acc ? S_ONE : S_EMPTY;
                w_load_head = w_acc;
            end
            S_ONE: begin
                w_next      = (w_acc && !w_emit) ? S_TWO : (!w_acc && w_emit) ? S_EMPTY : S_ONE;
                w_load_head = w_acc && w_emit;
                w_load_tail = w_acc && !w_emit;
            end
            S_TWO: begin
                w_next  = w_emit ? S_ONE : S_TWO;
                w_shift = w_emit;
            end
            default: w_next = S_EMPTY;
        endcase
        if (flush) begin
            w_next      = S_EMPTY;
            w_load_head = 1'b0;
            w_load_tail = 1'b0;
            w_shift     = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_head) r_head <= w_new;
            else if (w_shift) r_head <= r_tail;
            if (w_load_tail) r_tail <= w_new;
        end
    end
    assign out_pc     = r_head.pc;
    assign out_decode = r_head.decode;
    assign out_imm    = r_head.imm;
    assign out_rs1    = r_head.rs1;
    assign out_rs2    = r_head.rs2;
    assign out_rd     = r_head.rd;
    assign out_rd_we  = r_head.rd_we;
    assign out_csr    = r_head.csr;
`ifdef DECODE_STAGE_PERF_EN
    logic [PERF_W-1:0] r_stall_in, r_stall_out;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_in  <= '0;
            r_stall_out <= '0;
        end else begin
            if (in_valid && !in_ready) r_stall_in <= r_stall_in + PERF_W'(1);
            if (out_valid && !out_ready) r_stall_out <= r_stall_out + PERF_W'(1);
        end
    end
    assign perf_stall_in  = r_stall_in;
    assign perf_stall_out = r_stall_out;
`else
    assign perf_stall_in  = '0;
    assign perf_stall_out = '0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + randomized checks of decode_stage against a queue-based reference model.
module tb_decode_stage;
`ifdef DECODE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_instr = '0;
    logic        in_ready, out_valid, out_rd_we;
    logic [31:0] out_pc, out_imm, perf_stall_in, perf_stall_out;
    logic [14:0] out_decode;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [11:0] out_csr;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} txn_t;
    txn_t        q[$];
    int          checks = 0, errors = 0;
    int unsigned m_sin = 0, m_sout = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_decode(out_decode), .out_imm(out_imm), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_csr(out_csr),
        .perf_stall_in(perf_stall_in), .perf_stall_out(perf_stall_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int unsigned v, input int n);
        return (v >= (32'd1 << (n - 1))) ? v - (32'd1 << n) : v;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return sx(i[31:20], 12);
        if (op == 7'h23) return sx({i[31:25], i[11:7]}, 12);
        if (op == 7'h63) return sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
        if (op == 7'h37 || op == 7'h17) return i[31:12] * 32'd4096;
        if (op == 7'h6f) return sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
        if (op == 7'h73 && i[14]) return 32'(i[19:15]);
        return 32'd0;
    endfunction

    function automatic logic [14:0] m_dec(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [1:0] unit = 2'd0;
        logic [2:0] sub = 3'd0;
        logic [3:0] sel = 4'd0;
        bit imm = 0, fence = 0, ecall = 0, ebreak = 0, ill = 0, cj = 0;
        case (op)
            7'h37: begin sub = 3; imm = 1; end
            7'h17: begin sub = 4; imm = 1; end
            7'h6f: begin sub = 5; cj = 1; end
            7'h67: begin sub = 6; cj = 1; ill = f3 != 0; end
            7'h63: begin sub = 1; cj = 1; sel = 4'(f3); ill = f3 == 2 || f3 == 3; end
            7'h03: begin unit = 1; imm = 1; sel = 4'(f3); ill = f3 == 3 || f3 == 6 || f3 == 7; end
            7'h23: begin unit = 1; sub = 1; imm = 1; sel = 4'(f3); ill = f3 > 2; end
            7'h13: begin sub = 2; imm = 1; sel = 4'(f3) + ((f3 == 5 && i[30]) ? 4'd8 : 4'd0); end
            7'h33: begin
                sel = 4'(f3) + (i[30] ? 4'd8 : 4'd0);
                ill = !(i[31:25] == 0 || (i[31:25] == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h0f: begin unit = 2; sub = 2; fence = 1; end
            7'h73: begin
                unit = 2;
                if (f3 == 0) begin
                    sub = 1; ecall = i == 32'h00000073; ebreak = i == 32'h00100073; ill = !(ecall || ebreak);
                end else begin
                    sel = 4'(f3); imm = f3 >= 4; ill = f3 == 4;
                end
            end
            default: ill = 1;
        endcase
        if (i[1:0] != 2'b11) ill = 1;
        return {unit, sub, sel, imm, fence, ecall, ebreak, ill, cj};
    endfunction

    function automatic logic m_rd_we(input logic [31:0] i);
        logic [14:0] d = m_dec(i);
        return !(i[6:0] == 7'h63 || i[6:0] == 7'h23 || d[4] || d[3] || d[2] || d[1] || i[11:7] == 5'd0);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [31:0] i = $urandom();
        int          k = $urandom_range(0, 11);
        if (k < 11) i[6:0] = ops[k];
        if (k == 8 && $urandom_range(0, 1) == 1) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (k == 10 && $urandom_range(0, 3) == 0) i = ($urandom_range(0, 1) == 1) ? 32'h00000073 : 32'h00100073;
        return i;
    endfunction

    task automatic check_outputs();
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_decode", out_decode, m_dec(q[0].instr));
            check("out_imm", out_imm, m_imm(q[0].instr));
            check("out_rs1", out_rs1, q[0].instr[19:15]);
            check("out_rs2", out_rs2, q[0].instr[24:20]);
            check("out_rd", out_rd, q[0].instr[11:7]);
            check("out_rd_we", out_rd_we, m_rd_we(q[0].instr));
            check("out_csr", out_csr, q[0].instr[31:20]);
        end
        check("perf_stall_in", perf_stall_in, PERF ? m_sin : 0);
        check("perf_stall_out", perf_stall_out, PERF ? m_sout : 0);
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy, input logic fl);
        bit   acc, emit;
        txn_t t;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
        acc  = v && q.size() < 2;
        emit = q.size() > 0 && rdy;
        if (v && q.size() >= 2) m_sin++;
        if (q.size() > 0 && !rdy) m_sout++;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (emit) void'(q.pop_front());
            if (acc) begin t.pc = pc; t.instr = ins; q.push_back(t); end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic        v, hold;
        logic [31:0] pc, ins;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_decode", out_decode, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_rd_we", out_rd_we, 0);
        check("rst_perf", {perf_stall_in, perf_stall_out}, 0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);
        step(1, 32'h100, 32'hFFF00093, 1, 0);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_rd", out_rd, 1);
        check("addi_rd_we", out_rd_we, 1);
        check("addi_decode_hi", out_decode[14:5], {2'd0, 3'd2, 4'd0, 1'b1});
        step(1, 32'h104, 32'hFE000EE3, 1, 0);
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        check("beq_calc_j", out_decode[0], 1);
        check("beq_sub_sel", out_decode[12:6], {3'd1, 4'd0});
        check("beq_rd_we", out_rd_we, 0);
        step(1, 32'h108, 32'h123452B7, 1, 0);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_rd", out_rd, 5);
        check("lui_rd_we", out_rd_we, 1);
        step(1, 32'h10C, 32'h00000000, 1, 0);
        check("zero_illegal", out_decode[1], 1);
        check("zero_rd_we", out_rd_we, 0);
        step(0, 0, 0, 1, 0);
        check("drained", out_valid, 0);
        step(1, 32'h200, 32'h00100093, 0, 0);
        step(1, 32'h204, 32'h00200113, 0, 0);
        check("b2b_full", in_ready, 0);
        step(1, 32'h208, 32'h00300193, 0, 0);
        check("b2b_hold_head", out_pc, 32'h200);
        step(1, 32'h208, 32'h00300193, 1, 0);
        check("b2b_head2", out_pc, 32'h204);
        step(1, 32'h208, 32'h00300193, 1, 0);
        check("b2b_head3", out_pc, 32'h208);
        step(0, 0, 0, 1, 0);
        check("b2b_done", out_valid, 0);
        step(1, 32'h300, 32'h00100093, 0, 0);
        step(1, 32'h304, 32'h00200113, 0, 0);
        step(1, 32'h308, 32'h00300193, 0, 1);
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        step(0, 0, 0, 1, 0);
        check("flush_no_emit", out_valid, 0);
        v = 0; pc = 0; ins = 0;
        for (int n = 0; n < 3000; n++) begin
            hold = in_valid && q.size() >= 2;
            if (!hold) begin
                v = $urandom_range(0, 3) != 0;
                pc = $urandom();
                ins = rand_instr();
            end
            step(v, pc, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        step(1, 32'h400, 32'h00100093, 0, 0);
        step(1, 32'h404, 32'h00200113, 0, 0);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 0);
        check("async_rst_pc", out_pc, 0);
        q.delete(); m_sin = 0; m_sout = 0; in_valid = 1'b0;
        @(negedge clk);
        check("async_rst_perf", {perf_stall_in, perf_stall_out}, 0);
        rst = 1'b0;
        step(1, 32'h500, 32'h123452B7, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        check("perf_out_10", perf_stall_out, PERF ? 10 : 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
